// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : alu_multicycle
//  Description : Execute-stage ALU for an RV32IM core. Logic, add/sub, shift
//                and compare ops finish in one cycle. MUL/DIV/REM iterate
//                one bit per cycle. Valid/ready handshake on both sides.
//                Optional build macro ALU_FAST_MUL_EN switches MUL* ops to a
//                combinational multiplier with single-cycle latency.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_multicycle #(
    parameter int XLEN = 32,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [OPW-1:0] c_OP_AND    = OPW'(0);
    localparam logic [OPW-1:0] c_OP_OR     = OPW'(1);
    localparam logic [OPW-1:0] c_OP_XOR    = OPW'(3);
    localparam logic [OPW-1:0] c_OP_SLL    = OPW'(4);
    localparam logic [OPW-1:0] c_OP_SRL    = OPW'(5);
    localparam logic [OPW-1:0] c_OP_SUB    = OPW'(6);
    localparam logic [OPW-1:0] c_OP_SRA    = OPW'(7);
    localparam logic [OPW-1:0] c_OP_SLT    = OPW'(8);
    localparam logic [OPW-1:0] c_OP_SLTU   = OPW'(9);
    localparam logic [OPW-1:0] c_OP_MUL    = OPW'(16);
    localparam logic [OPW-1:0] c_OP_MULH   = OPW'(17);
    localparam logic [OPW-1:0] c_OP_MULHSU = OPW'(18);
    localparam logic [OPW-1:0] c_OP_MULHU  = OPW'(19);
    localparam logic [OPW-1:0] c_OP_DIV    = OPW'(20);
    localparam logic [OPW-1:0] c_OP_REMU   = OPW'(23);
    localparam logic [SHW-1:0] c_CNT_LAST  = SHW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [SHW-1:0]  r_cnt;
    logic [XLEN-1:0] r_a;        // multiplicand magnitude
    logic [XLEN-1:0] r_b;        // divisor magnitude
    logic [XLEN-1:0] r_hi;       // product high half / partial remainder
    logic [XLEN-1:0] r_lo;       // multiplier bits / quotient bits
    logic            r_neg;      // product or quotient must be negated
    logic            r_neg_r;    // remainder must be negated (dividend sign)
    logic [1:0]      r_sel;      // low bits of the op select the final variant

    logic            w_accept;
    logic            w_is_mul;
    logic            w_is_div;
    logic            w_iter_mul;
    logic            w_single;
    logic            w_last;
    logic            w_load;
    logic [XLEN-1:0] w_ld_val;

    // ------------------------------------------------------------------------
    // Operand classification and magnitudes for the iterative paths
    // ------------------------------------------------------------------------
    logic            w_sa, w_sb;
    logic            w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;

    assign w_is_mul = (op >= c_OP_MUL) && (op <= c_OP_MULHU);
    assign w_is_div = (op >= c_OP_DIV) && (op <= c_OP_REMU);

    // Signedness of each operand: MULH s*s, MULHSU s*u, DIV/REM s/s
    assign w_sa    = w_is_mul ? ((op == c_OP_MULH) || (op == c_OP_MULHSU))
                              : (w_is_div && !op[0]);
    assign w_sb    = w_is_mul ? (op == c_OP_MULH) : (w_is_div && !op[0]);
    assign w_a_neg = w_sa && src_a[XLEN-1];
    assign w_b_neg = w_sb && src_b[XLEN-1];
    assign w_a_mag = w_a_neg ? (-src_a) : src_a;
    assign w_b_mag = w_b_neg ? (-src_b) : src_b;

`ifdef ALU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fa, w_fb, w_fprod;
    assign w_fa       = {{XLEN{w_a_neg}}, src_a};
    assign w_fb       = {{XLEN{w_b_neg}}, src_b};
    assign w_fprod    = w_fa * w_fb;
    assign w_iter_mul = 1'b0;
`else
    assign w_iter_mul = w_is_mul;
`endif

    assign w_single = !w_is_div && !w_iter_mul;
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------------
    // Single-cycle ALU; unlisted codes fall through to ADD
    // ------------------------------------------------------------------------
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_alu;
    assign w_shamt = src_b[SHW-1:0];

    // Combinational result for the one-cycle ops
    always_comb begin
        w_alu = src_a + src_b;
        case (op)
            c_OP_AND:  w_alu = src_a & src_b;
            c_OP_OR:   w_alu = src_a | src_b;
            c_OP_XOR:  w_alu = src_a ^ src_b;
            c_OP_SLL:  w_alu = src_a << w_shamt;
            c_OP_SRL:  w_alu = src_a >> w_shamt;
            c_OP_SUB:  w_alu = src_a - src_b;
            c_OP_SRA:  w_alu = $unsigned($signed(src_a) >>> w_shamt);
            c_OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            c_OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (src_a < src_b)};
`ifdef ALU_FAST_MUL_EN
            c_OP_MUL:    w_alu = w_fprod[XLEN-1:0];
            c_OP_MULH,
            c_OP_MULHSU,
            c_OP_MULHU:  w_alu = w_fprod[2*XLEN-1:XLEN];
`endif
            default:   w_alu = src_a + src_b;
        endcase
    end

    // ------------------------------------------------------------------------
    // One step of shift-add multiply and restoring divide
    // ------------------------------------------------------------------------
    logic [XLEN:0]     w_sum;
    logic [XLEN-1:0]   w_mhi_nxt, w_mlo_nxt;
    logic [XLEN:0]     w_rsh;
    logic [XLEN-1:0]   w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_dhi_nxt, w_dlo_nxt;
    logic [2*XLEN-1:0] w_mfix;
    logic [XLEN-1:0]   w_qfix, w_rfix;
    logic [XLEN-1:0]   w_iter_res;

    assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
    assign w_mhi_nxt = w_sum[XLEN:1];
    assign w_mlo_nxt = {w_sum[0], r_lo[XLEN-1:1]};

    // A zero divisor always "fits", giving all-ones quotient and remainder = dividend
    assign w_rsh     = {r_hi, r_lo[XLEN-1]};
    assign w_ge      = (w_rsh >= {1'b0, r_b});
    assign w_diff    = w_rsh[XLEN-1:0] - r_b;
    assign w_dhi_nxt = w_ge ? w_diff : w_rsh[XLEN-1:0];
    assign w_dlo_nxt = {r_lo[XLEN-2:0], w_ge};

    assign w_mfix = r_neg   ? (-{w_mhi_nxt, w_mlo_nxt}) : {w_mhi_nxt, w_mlo_nxt};
    assign w_qfix = r_neg   ? (-w_dlo_nxt) : w_dlo_nxt;
    assign w_rfix = r_neg_r ? (-w_dhi_nxt) : w_dhi_nxt;

    assign w_iter_res = (r_state == S_MUL)
                      ? ((r_sel == 2'b00) ? w_mfix[XLEN-1:0] : w_mfix[2*XLEN-1:XLEN])
                      : (r_sel[1] ? w_rfix : w_qfix);

    assign w_load   = (w_accept && w_single) || (busy && w_last);
    assign w_ld_val = busy ? w_iter_res : w_alu;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state plus handshake/stall outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = rst_n && (!out_valid || out_ready);
                if (w_accept && w_iter_mul)    w_state_nxt = S_MUL;
                else if (w_accept && w_is_div) w_state_nxt = S_DIV;
            end
            S_MUL, S_DIV: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Iteration registers: operands captured on accept, one step per busy cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg   <= 1'b0;
            r_neg_r <= 1'b0;
            r_sel   <= 2'b00;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_a     <= w_a_mag;
            r_b     <= w_b_mag;
            r_hi    <= '0;
            r_lo    <= w_is_div ? w_a_mag : w_b_mag;
            r_neg   <= (w_a_neg ^ w_b_neg) && !(w_is_div && (src_b == '0));
            r_neg_r <= w_a_neg;
            r_sel   <= op[1:0];
        end else if (busy) begin
            r_cnt <= r_cnt + 1'b1;
            r_hi  <= (r_state == S_MUL) ? w_mhi_nxt : w_dhi_nxt;
            r_lo  <= (r_state == S_MUL) ? w_mlo_nxt : w_dlo_nxt;
        end
    end

    // Output register: load wins over drain, held while stalled downstream
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            result    <= w_ld_val;
            zero      <= (w_ld_val == '0);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_multicycle
//  Description : Self-checking bench for alu_multicycle: directed cases with
//                literal expectations, backpressure, reset mid-divide, then
//                randomized traffic checked every cycle against a model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_multicycle;

    localparam int XLEN = 32;
`ifdef ALU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        in_ready, out_valid, zero, busy;
    logic [31:0] result;

    alu_multicycle #(.XLEN(XLEN), .OPW(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout(string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_iter(logic [4:0] o);
`ifdef ALU_FAST_MUL_EN
        return (o >= 20) && (o <= 23);
`else
        return (o >= 16) && (o <= 23);
`endif
    endfunction

    function automatic logic [31:0] ref_alu(logic [4:0] o, logic [31:0] a, logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (o)
            0:  r = a & b;
            1:  r = a | b;
            3:  r = a ^ b;
            4:  r = a << b[4:0];
            5:  r = a >> b[4:0];
            6:  r = a - b;
            7:  r = $unsigned($signed(a) >>> b[4:0]);
            8:  r = (sa < sb) ? 32'd1 : 32'd0;
            9:  r = (a < b) ? 32'd1 : 32'd0;
            16: begin p = 64'(ua * ub); r = p[31:0]; end
            17: begin p = 64'(sa * sb); r = p[63:32]; end
            18: begin p = 64'(sa * ub); r = p[63:32]; end
            19: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            20: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = 64'(sa / sb); r = p[31:0]; end
            end
            21: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            22: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else begin p = 64'(sa % sb); r = p[31:0]; end
            end
            23: r = (b == 0) ? a : a % b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    // Model state: output register and remaining edges of an iterative op
    int          pend = 0;
    logic [31:0] pend_val = '0;
    logic        exp_ov = 1'b0;
    logic [31:0] exp_res = '0;
    logic        exp_zero = 1'b0;
    bit          started = 1'b0;

    // Model advances on each rising edge from the bench-driven inputs
    always @(posedge clk) begin : model
        logic        rdy, ld;
        logic [31:0] v;
        rdy = rst_n && (pend == 0) && (!exp_ov || out_ready);
        ld  = 1'b0;
        v   = '0;
        if (!rst_n) begin
            pend = 0; exp_ov = 1'b0; exp_res = '0; exp_zero = 1'b0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin ld = 1'b1; v = pend_val; end
            end else if (in_valid && rdy) begin
                if (is_iter(op)) begin pend = XLEN; pend_val = ref_alu(op, src_a, src_b); end
                else begin ld = 1'b1; v = ref_alu(op, src_a, src_b); end
            end
            if (ld) begin exp_ov = 1'b1; exp_res = v; exp_zero = (v == 0); end
            else if (out_ready) exp_ov = 1'b0;
        end
        started = 1'b1;
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", {31'h0, out_valid}, {31'h0, exp_ov});
            chk("result",    result, exp_res);
            chk("zero",      {31'h0, zero}, {31'h0, exp_zero});
            chk("busy",      {31'h0, busy}, {31'h0, (pend > 0)});
            chk("in_ready",  {31'h0, in_ready},
                {31'h0, (rst_n && (pend == 0) && (!exp_ov || out_ready))});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_ready(string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        if (!ok) timeout(name);
    endtask

    task automatic run_op(string name, logic [4:0] o, logic [31:0] a, logic [31:0] b,
                          logic [31:0] exp, int exp_lat);
        int lat, nbusy;
        bit got, ok;
        @(negedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; op = o; src_a = a; src_b = b;
        wait_ready(name, ok);
        if (ok) begin
            @(posedge clk); #1;
            in_valid = 1'b0; src_a = $urandom; src_b = $urandom; op = 5'($urandom);
            lat = 0; nbusy = 0; got = 1'b0;
            for (int i = 0; i < 45; i++) begin
                @(negedge clk);
                lat++;
                if (out_valid) begin got = 1'b1; break; end
                if (busy) nbusy++;
            end
            if (!got) timeout(name);
            else begin
                chk({name, " result"},  result, exp);
                chk({name, " zero"},    {31'h0, zero}, {31'h0, (exp == 0)});
                chk({name, " latency"}, lat, exp_lat);
                chk({name, " busy_cycles"}, nbusy, exp_lat - 1);
            end
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset result", result, 32'h0);
        chk("reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset in_ready", {31'h0, in_ready}, 32'h0);
        #1 rst_n = 1'b1;

        run_op("add_ovf",  5'd2,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1);
        run_op("sub_zero", 5'd6,  32'd5,         32'd5,         32'h0,         1);
        run_op("mulhu",    5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mul",      5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT);
        run_op("mulh_neg", 5'd17, 32'hFFFF_FFFD, 32'd2,         32'hFFFF_FFFF, MUL_LAT);
        run_op("mulhsu",   5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("div_ovf",  5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT);
        run_op("rem_ovf",  5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         DIV_LAT);
        run_op("divu_z",   5'd21, 32'd7,         32'd0,         32'hFFFF_FFFF, DIV_LAT);
        run_op("remu_z",   5'd23, 32'd7,         32'd0,         32'd7,         DIV_LAT);
        run_op("div_z_neg",5'd20, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, DIV_LAT);
        run_op("div_neg",  5'd20, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_neg",  5'd22, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
        run_op("sra",      5'd7,  32'h8000_0000, 32'h24,        32'hF800_0000, 1);
        run_op("slt",      5'd8,  32'd1,         32'hFFFF_FFFF, 32'h0,         1);
        run_op("sltu",     5'd9,  32'd1,         32'hFFFF_FFFF, 32'h1,         1);
        run_op("other",    5'd31, 32'd3,         32'd4,         32'd7,         1);

        // Backpressure: result held while stalled, then drain and accept together
        @(negedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; op = 5'd2; src_a = 32'd10; src_b = 32'd20;
        wait_ready("bp", ok);
        @(posedge clk); #1;
        op = 5'd6; src_a = 32'd9; src_b = 32'd4;
        repeat (3) begin
            @(negedge clk);
            chk("bp in_ready", {31'h0, in_ready}, 32'h0);
            chk("bp held",     result, 32'd30);
            chk("bp valid",    {31'h0, out_valid}, 32'h1);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp back2back", result, 32'd5);
        chk("bp b2b valid", {31'h0, out_valid}, 32'h1);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp drained", {31'h0, out_valid}, 32'h0);

        // Reset in the middle of a divide
        @(negedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; op = 5'd20; src_a = 32'd100; src_b = 32'd7;
        wait_ready("rst_div", ok);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid busy",      {31'h0, busy}, 32'h0);
        chk("rst_mid out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_mid result",    result, 32'h0);
        chk("rst_mid in_ready",  {31'h0, in_ready}, 32'h0);
        #1 rst_n = 1'b1;
        run_op("after_rst", 5'd21, 32'd100, 32'd7, 32'd14, DIV_LAT);

        // Randomized traffic; the compare process checks every cycle
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op        = 5'($urandom_range(0, 31));
            src_a     = rnd_operand();
            src_b     = rnd_operand();
        end
        @(negedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
